// File: rtl/board_state.sv
// -----------------------------------------------------------------------------
// board_state
//
// Sequential 8x8 board register file. Accepts one move command at a time over
// a valid/ready handshake, checks that the source holds a piece of the side to
// move and that the destination is not one of its own pieces, applies the
// move, and tracks side-to-move plus a sticky game-over flag that is set when a
// king is captured. No piece-movement legality is checked here; that belongs
// to the downstream/upstream per-piece checkers fed from boardPos.
//
// Square code: bit0 = occupied, bit1 = colour (1 = black, 0 when empty),
//              bit2 = king.
//
// Handshake: a move is transferred on a rising edge where move_valid and
// move_ready are both 1. move_ready is 1 only in IDLE while game_over is 0.
// The response (move_done or move_err) is a single-cycle pulse two cycles
// after the accepting edge; the next move can be accepted one cycle later.
//
// Optional feature macro: BOARD_LOAD_EN
//   Adds load_valid/load_row/load_col/load_data. A load writes one square in
//   IDLE when move_valid is 0, and is accepted even after game over.
//
// Ports:
//   clk, reset                    rising-edge clock, async active-high reset
//   move_valid / move_ready       move command handshake
//   from_row/from_col/to_row/to_col  move coordinates (row 0 = top, col 0 = left)
//   move_done / move_err          one-cycle response pulses
//   err_code                      1 src empty, 2 wrong colour, 3 own dst / from==to
//   captured                      code removed from destination (with move_done)
//   turn                          side to move (0 white, 1 black)
//   game_over                     sticky, set on king capture
//   boardPos                      boardPos[row][col] = 3-bit square code
//   o_dbg_state                   current FSM state (debug)
// -----------------------------------------------------------------------------
module board_state #(
    parameter bit INIT_STANDARD = 1'b1,
    parameter bit START_COLOR   = 1'b0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  move_valid,
    output logic                  move_ready,
    input  logic [2:0]            from_row,
    input  logic [2:0]            from_col,
    input  logic [2:0]            to_row,
    input  logic [2:0]            to_col,
    output logic                  move_done,
    output logic                  move_err,
    output logic [1:0]            err_code,
    output logic [2:0]            captured,
    output logic                  turn,
    output logic                  game_over,
    output logic [7:0][7:0][2:0]  boardPos,
`ifdef BOARD_LOAD_EN
    input  logic                  load_valid,
    input  logic [2:0]            load_row,
    input  logic [2:0]            load_col,
    input  logic [2:0]            load_data,
`endif
    output logic [1:0]            o_dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CHECK = 2'd1,
        S_WRITE = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t               r_state;
    state_t               w_state_next;

    logic [7:0][7:0][2:0] r_board;
    logic                 r_turn;
    logic                 r_game_over;
    logic [1:0]           r_err;
    logic [2:0]           r_captured;
    logic [2:0]           r_from_row;
    logic [2:0]           r_from_col;
    logic [2:0]           r_to_row;
    logic [2:0]           r_to_col;

    logic                 w_ready;
    logic                 w_accept;
    logic [2:0]           w_src;
    logic [2:0]           w_dst;
    logic                 w_same_sq;
    logic [1:0]           w_err_calc;

    // Reset image of the board.
    function automatic logic [7:0][7:0][2:0] init_board();
        logic [7:0][7:0][2:0] b;
        b = '0;
        if (INIT_STANDARD) begin
            for (int r = 0; r < 8; r++) begin
                for (int c = 0; c < 8; c++) begin
                    if (r <= 1) begin
                        b[r[2:0]][c[2:0]] = 3'b011;
                    end else if (r >= 6) begin
                        b[r[2:0]][c[2:0]] = 3'b001;
                    end
                end
            end
            b[0][4] = 3'b111;
            b[7][4] = 3'b101;
        end
        return b;
    endfunction

    assign w_src     = r_board[r_from_row][r_from_col];
    assign w_dst     = r_board[r_to_row][r_to_col];
    assign w_same_sq = (r_from_row == r_to_row) && (r_from_col == r_to_col);

    // Ownership checks in priority order: empty source, wrong colour,
    // then own-colour destination or a null move.
    always_comb begin
        w_err_calc = 2'd0;
        if (!w_src[0]) begin
            w_err_calc = 2'd1;
        end else if (w_src[1] != r_turn) begin
            w_err_calc = 2'd2;
        end else if ((w_dst[0] && (w_dst[1] == r_turn)) || w_same_sq) begin
            w_err_calc = 2'd3;
        end
    end

    // Next-state and handshake/response outputs.
    always_comb begin
        w_state_next = r_state;
        w_ready      = 1'b0;
        w_accept     = 1'b0;
        move_done    = 1'b0;
        move_err     = 1'b0;
        err_code     = 2'd0;
        captured     = 3'd0;
        case (r_state)
            S_IDLE: begin
                w_ready  = !r_game_over;
                w_accept = w_ready && move_valid;
                if (w_accept) begin
                    w_state_next = S_CHECK;
                end
            end
            S_CHECK: begin
                w_state_next = S_WRITE;
            end
            S_WRITE: begin
                w_state_next = S_RESP;
            end
            S_RESP: begin
                move_done    = (r_err == 2'd0);
                move_err     = (r_err != 2'd0);
                err_code     = r_err;
                captured     = (r_err == 2'd0) ? r_captured : 3'd0;
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
        end else begin
            r_state     <= w_state_next;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_board     <= init_board();
            r_turn      <= START_COLOR;
            r_game_over <= 1'b0;
            r_err       <= 2'd0;
            r_captured  <= 3'd0;
            r_from_row  <= 3'd0;
            r_from_col  <= 3'd0;
            r_to_row    <= 3'd0;
            r_to_col    <= 3'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_from_row <= from_row;
                        r_from_col <= from_col;
                        r_to_row   <= to_row;
                        r_to_col   <= to_col;
                    end
`ifdef BOARD_LOAD_EN
                    // Loads only while no move is being offered, so a load
                    // can never collide with an accept on the same edge.
                    else if (load_valid && !move_valid) begin
                        r_board[load_row][load_col] <= load_data;
                    end
`endif
                end
                S_CHECK: begin
                    r_err <= w_err_calc;
                end
                S_WRITE: begin
                    if (r_err == 2'd0) begin
                        // from != to is guaranteed here, so both writes land.
                        r_board[r_to_row][r_to_col]     <= w_src;
                        r_board[r_from_row][r_from_col] <= 3'd0;
                        r_captured                      <= w_dst;
                    end else begin
                        r_captured                      <= 3'd0;
                    end
                end
                S_RESP: begin
                    if (r_err == 2'd0) begin
                        r_turn <= !r_turn;
                        if (r_captured[2]) begin
                            r_game_over <= 1'b1;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign move_ready  = w_ready;
    assign turn        = r_turn;
    assign game_over   = r_game_over;
    assign boardPos    = r_board;
    assign o_dbg_state = r_state;

endmodule
